// File: rtl/ad7671_pkg.sv
// Shared types and constants for the AD7671 conversion sequencer.
package ad7671_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CNV       = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_READ      = 3'd4,
    ST_GAP       = 3'd5
  } scan_state_e;

  // Fixed dwell after CNVST so BUSY has risen and crossed the synchroniser.
  localparam int SETTLE_CYC = 4;

  // Width of the shared phase counter (CNV, SETTLE, WAIT_BUSY, READ).
  localparam int CNT_W = 16;

  // Channel-index width; a single chip still carries a 1-bit tag.
  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/ad7671_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered head and status.
module ad7671_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  input  logic               rd_en_i,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              wr_ok_s, rd_ok_s;

  // Next pointers, occupancy and the head word that will be visible next cycle.
  always_comb begin
    // A write into a full FIFO is only allowed when the head leaves the same cycle.
    wr_ok_s  = wr_en_i && (!full_q || rd_en_i);
    rd_ok_s  = rd_en_i && !empty_q;
    wr_ptr_d = wr_ok_s ? (wr_ptr_q + ADDR_W'(1)) : wr_ptr_q;
    rd_ptr_d = rd_ok_s ? (rd_ptr_q + ADDR_W'(1)) : rd_ptr_q;
    count_d  = count_q + {{ADDR_W{1'b0}}, wr_ok_s} - {{ADDR_W{1'b0}}, rd_ok_s};
    full_d   = (count_d == (ADDR_W+1)'(DEPTH));
    empty_d  = (count_d == {(ADDR_W+1){1'b0}});
    if (empty_d) begin
      rd_data_d = {WIDTH{1'b0}};
    end else if (wr_ok_s && (rd_ptr_d == wr_ptr_q)) begin
      // New head is the word being written this cycle (bypass the array).
      rd_data_d = wr_data_i;
    end else begin
      rd_data_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array; contents need no reset since the head register masks them.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointer, count, status and head registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= {ADDR_W{1'b0}};
      rd_ptr_q  <= {ADDR_W{1'b0}};
      count_q   <= {(ADDR_W+1){1'b0}};
      rd_data_q <= {WIDTH{1'b0}};
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign count_o   = count_q;

endmodule

// File: rtl/ad7671_scan_ctrl.sv
// Conversion sequencer for a bank of AD7671 ADCs on a shared data bus:
// drives CNVST, waits for BUSY, strobes RD per enabled chip and queues
// channel-tagged samples in a FWFT FIFO.
module ad7671_scan_ctrl
  import ad7671_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int DATA_W       = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNV_LOW_CYC  = 2,
  parameter int RD_CYC       = 3,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          cont,
  input  logic                          stop,
  input  logic [N_CH-1:0]               ch_mask,
  input  logic [15:0]                   scan_period,
  input  logic                          clr_err,
  output logic                          adc_cnvst_n,
  output logic [N_CH-1:0]               adc_rd_n,
  input  logic [N_CH-1:0]               adc_busy,
  input  logic [DATA_W-1:0]             adc_data,
  input  logic                          fifo_rd,
  output logic [ch_w(N_CH)+DATA_W-1:0]  fifo_dout,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          active,
  output logic                          overrun,
  output logic                          timeout
);

  localparam int CH_W = ch_w(N_CH);

  scan_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       per_q, per_d;
  logic [N_CH-1:0]   mask_q, mask_d;
  logic              cont_q, cont_d;
  logic              stop_q, stop_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [N_CH-1:0]   busy_s1_q, busy_s2_q;
  logic              cnvst_n_q, cnvst_n_d;
  logic [N_CH-1:0]   rd_n_q, rd_n_d;
  logic              active_q;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic              push_s, tmo_set_s, busy_clr_s, fifo_full_s;
  logic              nxt_vld_s;
  logic [CH_W-1:0]   nxt_ch_s;

  // Lowest enabled channel: from 0 when entering READ, above the current one inside READ.
  always_comb begin
    nxt_vld_s = 1'b0;
    nxt_ch_s  = {CH_W{1'b0}};
    for (int i = N_CH - 1; i >= 0; i--) begin
      nxt_vld_s = nxt_vld_s | (mask_q[i] && ((state_q != ST_READ) || (i > int'(ch_q))));
      nxt_ch_s  = (mask_q[i] && ((state_q != ST_READ) || (i > int'(ch_q)))) ? CH_W'(i) : nxt_ch_s;
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    mask_d     = mask_q;
    cont_d     = cont_q;
    stop_d     = stop_q | stop;
    ch_d       = ch_q;
    data_d     = data_q;
    push_s     = 1'b0;
    tmo_set_s  = 1'b0;
    busy_clr_s = ((busy_s2_q & mask_q) == {N_CH{1'b0}});
    per_d      = (per_q == 16'hFFFF) ? per_q : (per_q + 16'd1);

    case (state_q)
      ST_IDLE: begin
        cnt_d  = {CNT_W{1'b0}};
        stop_d = 1'b0;
        cont_d = 1'b0;
        if (start && (ch_mask != {N_CH{1'b0}})) begin
          mask_d  = ch_mask;
          cont_d  = cont;
          state_d = ST_CNV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CNV: begin
        if (cnt_q == CNT_W'(CNV_LOW_CYC - 1)) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_CNV;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_WAIT_BUSY;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_WAIT_BUSY: begin
        if (busy_clr_s) begin
          cnt_d   = {CNT_W{1'b0}};
          ch_d    = nxt_ch_s;
          state_d = ST_READ;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          // Abort the whole scan; nothing from this frame is queued.
          tmo_set_s = 1'b1;
          cont_d    = 1'b0;
          cnt_d     = {CNT_W{1'b0}};
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_READ: begin
        // cnt 0..RD_CYC-1: strobe low; cnt RD_CYC: all-high gap, push sample.
        if (cnt_q == CNT_W'(RD_CYC - 1)) begin
          data_d = adc_data;
        end else begin
          data_d = data_q;
        end
        if (cnt_q == CNT_W'(RD_CYC)) begin
          push_s = 1'b1;
          cnt_d  = {CNT_W{1'b0}};
          if (nxt_vld_s) begin
            ch_d    = nxt_ch_s;
            state_d = ST_READ;
          end else if (cont_q) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_READ;
        end
      end
      ST_GAP: begin
        if (stop_q || stop) begin
          state_d = ST_IDLE;
        end else if (({1'b0, per_q} + 17'd1) >= {1'b0, scan_period}) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_CNV;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        cont_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Period counter restarts on every CNVST falling edge.
    if ((state_d == ST_CNV) && (state_q != ST_CNV)) begin
      per_d = 16'd0;
    end else begin
      per_d = per_d;
    end
  end

  // Pin drive decoded from next state so the outputs come straight from flops.
  always_comb begin
    cnvst_n_d = (state_d != ST_CNV);
    rd_n_d    = {N_CH{1'b1}};
    if ((state_d == ST_READ) && (cnt_d < CNT_W'(RD_CYC))) begin
      rd_n_d[ch_d] = 1'b0;
    end else begin
      rd_n_d = {N_CH{1'b1}};
    end
  end

  // Sticky error flags; a new error beats a simultaneous clear.
  always_comb begin
    overrun_d = (push_s && fifo_full_s && !fifo_rd) ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
    timeout_d = tmo_set_s ? 1'b1 : (clr_err ? 1'b0 : timeout_q);
  end

  // State, datapath, synchroniser and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      per_q     <= 16'd0;
      mask_q    <= {N_CH{1'b0}};
      cont_q    <= 1'b0;
      stop_q    <= 1'b0;
      ch_q      <= {CH_W{1'b0}};
      data_q    <= {DATA_W{1'b0}};
      busy_s1_q <= {N_CH{1'b0}};
      busy_s2_q <= {N_CH{1'b0}};
      cnvst_n_q <= 1'b1;
      rd_n_q    <= {N_CH{1'b1}};
      active_q  <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      mask_q    <= mask_d;
      cont_q    <= cont_d;
      stop_q    <= stop_d;
      ch_q      <= ch_d;
      data_q    <= data_d;
      busy_s1_q <= adc_busy;
      busy_s2_q <= busy_s1_q;
      cnvst_n_q <= cnvst_n_d;
      rd_n_q    <= rd_n_d;
      active_q  <= (state_d != ST_IDLE);
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  ad7671_sync_fifo #(
    .WIDTH (CH_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (push_s),
    .wr_data_i ({ch_q, data_q}),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_dout),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign fifo_full   = fifo_full_s;
  assign adc_cnvst_n = cnvst_n_q;
  assign adc_rd_n    = rd_n_q;
  assign active      = active_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;

endmodule

// File: doc/ad7671_scan_ctrl.md
# ad7671_scan_ctrl

Hardware conversion sequencer for a bank of AD7671 16-bit SAR ADCs sharing one data bus and one conversion-start line. It issues CNVST, waits on the per-chip BUSY lines, strobes each enabled chip's RD in turn, and pushes channel-tagged samples into an internal FIFO read by the PC104 bus interface. It replaces host-driven bit-banging of WR/RD/BUSY and supports single-shot and free-running periodic scans over a parametrised channel count.

## Interface
- N_CH, 4: number of AD7671 chips; 1..8.
- DATA_W, 16: ADC data width.
- FIFO_DEPTH, 16: sample FIFO entries; power of two, ≥2.
- CNV_LOW_CYC, 2: cycles adc_cnvst_n is held low.
- RD_CYC, 3: cycles each adc_rd_n is held low; ≥2.
- BUSY_TIMEOUT, 1024: max cycles waiting for all BUSY low.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a scan when idle.
- cont  in  1  sampled at start: 1 = free-running, 0 = single frame.
- stop  in  1  pulse; free-running scan ends after the current frame.
- ch_mask  in  N_CH  enabled chips, sampled at start.
- scan_period  in  16  cycles between successive CNVST falling edges in free-running mode.
- clr_err  in  1  clears overrun and timeout.
- adc_cnvst_n  out  1  shared conversion start, active low.
- adc_rd_n  out  N_CH  per-chip read strobe, active low.
- adc_busy  in  N_CH  per-chip BUSY, asynchronous.
- adc_data  in  DATA_W  shared ADC data bus.
- fifo_rd  in  1  pop head entry.
- fifo_dout  out  CH_W+DATA_W  {channel index, sample}, first-word-fall-through; CH_W = max(1, clog2(N_CH)).
- fifo_empty, fifo_full  out  1  FIFO status.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy.
- active  out  1  high whenever state ≠ IDLE.
- overrun, timeout  out  1  sticky error flags.

## Operation
- adc_busy passes through a 2-flop synchroniser before use.
- States: IDLE, CNV, SETTLE, WAIT_BUSY, READ, GAP.
- IDLE: on start with ch_mask ≠ 0 latch mask/cont, load period counter, → CNV. start with mask 0 is ignored. start outside IDLE is ignored.
- CNV: adc_cnvst_n low CNV_LOW_CYC cycles → SETTLE.
- SETTLE: 4 fixed cycles (covers BUSY rise plus synchroniser delay) → WAIT_BUSY.
- WAIT_BUSY: when all enabled synchronised BUSY are low → READ at lowest enabled channel. Timeout counter reaching BUSY_TIMEOUT sets timeout, aborts the scan (cont cleared) → IDLE; no samples pushed.
- READ: for each enabled channel in ascending index, that adc_rd_n is low RD_CYC cycles; adc_data is registered on the last low cycle and pushed next cycle with its index. One idle (all-high) cycle separates strobes. Disabled channels are skipped with no cycles spent. After the last channel → GAP if cont, else IDLE.
- GAP: wait until period counter (running since CNVST fall) reaches scan_period, then reload → CNV. If already expired, → CNV next cycle. stop seen at any time during a free-running scan (latched) causes GAP → IDLE instead.
- FIFO push when full and no simultaneous pop: sample dropped, overrun set. Push and pop in the same cycle when full: both proceed. fifo_rd when empty is ignored.
- clr_err clears both flags; an error event in the same cycle wins.

## Timing
- Reset: adc_cnvst_n=1, adc_rd_n=all 1, active=0, overrun=0, timeout=0, FIFO empty (fifo_count=0, fifo_dout=0), state IDLE. Reset mid-scan aborts immediately; no partial strobe extends past the reset cycle.
- adc_cnvst_n falls the cycle after start is accepted.
- First adc_rd_n falls the cycle after WAIT_BUSY sees all BUSY low (≥2 cycles after pin BUSY fall).
- fifo_empty deasserts the cycle after the push; fifo_dout valid same cycle.
- Frame length (no wait) = CNV_LOW_CYC + 4 + 1 + k·(RD_CYC+1) for k enabled channels.

## Structure
- Package ad7671_pkg: state enum, SETTLE_CYC=4 constant, CH_W function.
- One sub-module: ad7671_sync_fifo (FWFT synchronous FIFO, parametrised width/depth, count/full/empty).

## Test plan
- Single shot, mask 4'b1111, BUSY model low after 20 cycles, data = 16'h1000+ch → 4 entries {0,1000}..{3,1003} in order, active falls, adc_cnvst_n low exactly 2 cycles.
- Mask 4'b1010 → only ch1, ch3 strobed, entries {1,…},{3,…}; start with mask 0 → no CNVST.
- Free-running, scan_period=200, 3 frames then stop → CNVST falls exactly 200 cycles apart, 12 entries, IDLE after frame 3.
- Hold BUSY ch2 high → timeout set at BUSY_TIMEOUT, no entries, IDLE; clr_err clears it.
- No FIFO reads, free-running 5 frames, FIFO_DEPTH 16 → fifo_full, 16 entries kept, overrun set; pop+push when full keeps count 16.
- rst_n low during READ of ch1 → all strobes high next cycle, FIFO empty, flags 0.
